// File: rtl/tonomat_change_arbiter_if.sv
// tonomat_change_arbiter_if: lane request, coin dispenser and stock signals of the change arbiter.
interface tonomat_change_arbiter_if #(parameter int STOCK_W = 6);
  logic               req_a, req_b;
  logic [3:0]         amt_a, amt_b;
  logic               gnt_a, gnt_b, done_a, done_b, fail_a, fail_b;
  logic               disp_r1, disp_r5, disp_ack;
  logic               refill;
  logic [STOCK_W-1:0] refill_r1, refill_r5, stock_r1, stock_r5;
  logic               busy;
  modport master (
    output req_a, req_b, amt_a, amt_b, disp_ack, refill, refill_r1, refill_r5,
    input  gnt_a, gnt_b, done_a, done_b, fail_a, fail_b, disp_r1, disp_r5, stock_r1, stock_r5, busy
  );
  modport slave (
    input  req_a, req_b, amt_a, amt_b, disp_ack, refill, refill_r1, refill_r5,
    output gnt_a, gnt_b, done_a, done_b, fail_a, fail_b, disp_r1, disp_r5, stock_r1, stock_r5, busy
  );
endinterface

// File: rtl/tonomat_change_arbiter.sv
// tonomat_change_arbiter: round-robin change payout for two lanes over one coin dispenser.
module tonomat_change_arbiter #(
  parameter int STOCK_W = 6,
  parameter int INIT_R1 = 20,
  parameter int INIT_R5 = 10
) (
  input logic clk_i,
  input logic rst_ni,
  tonomat_change_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, PAY5, PAY1, REL5, REL1, FIN} state_e;
  state_e state_q, state_d;
  logic owner_q, owner_d, rr_q, rr_d, fail_q, fail_d, pick;
  logic [3:0] amt_q, amt_d, n5_q, n5_d, n1_q, n1_d, q5, c5, c1;
  logic [STOCK_W-1:0] s1_q, s1_d, s5_q, s5_d;
  logic [STOCK_W:0] sum1, sum5;
  logic gnt_a_q, gnt_b_q, done_a_q, done_b_q, fail_a_q, fail_b_q, disp_r1_q, disp_r5_q, busy_q;
  always_comb begin
    sum1 = {1'b0, s1_q} + {1'b0, bus.refill_r1};
    sum5 = {1'b0, s5_q} + {1'b0, bus.refill_r5};
    q5 = amt_q / 4'd5;
    c5 = (STOCK_W'(q5) > s5_q) ? 4'(s5_q) : q5;
    c1 = amt_q - c5 * 4'd5;
    pick = (bus.req_a & bus.req_b) ? rr_q : bus.req_b;
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    fail_d = fail_q;
    amt_d = amt_q;
    n5_d = n5_q;
    n1_d = n1_q;
    s1_d = s1_q;
    s5_d = s5_q;
    case (state_q)
      IDLE: begin
        if (bus.refill) begin
          s1_d = sum1[STOCK_W] ? '1 : sum1[STOCK_W-1:0];
          s5_d = sum5[STOCK_W] ? '1 : sum5[STOCK_W-1:0];
        end else if (bus.req_a | bus.req_b) begin
          owner_d = pick;
          amt_d = pick ? bus.amt_b : bus.amt_a;
          state_d = CHECK;
        end
      end
      CHECK: begin
        n5_d = c5;
        n1_d = c1;
        fail_d = STOCK_W'(c1) > s1_q;
        state_d = (fail_d || amt_q == 4'd0) ? FIN : (c5 != 4'd0) ? PAY5 : PAY1;
      end
      PAY5: if (bus.disp_ack) begin
        s5_d = s5_q - STOCK_W'(1);
        n5_d = n5_q - 4'd1;
        state_d = REL5;
      end
      REL5: if (!bus.disp_ack) state_d = (n5_q != 4'd0) ? PAY5 : (n1_q != 4'd0) ? PAY1 : FIN;
      PAY1: if (bus.disp_ack) begin
        s1_d = s1_q - STOCK_W'(1);
        n1_d = n1_q - 4'd1;
        state_d = REL1;
      end
      REL1: if (!bus.disp_ack) state_d = (n1_q != 4'd0) ? PAY1 : FIN;
      FIN: begin
        rr_d = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each one is valid for the whole state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q <= 1'b0;
      fail_q <= 1'b0;
      amt_q <= '0;
      n5_q <= '0;
      n1_q <= '0;
      s1_q <= STOCK_W'(INIT_R1);
      s5_q <= STOCK_W'(INIT_R5);
      {gnt_a_q, gnt_b_q, done_a_q, done_b_q, fail_a_q, fail_b_q} <= '0;
      {disp_r1_q, disp_r5_q, busy_q} <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      fail_q <= fail_d;
      amt_q <= amt_d;
      n5_q <= n5_d;
      n1_q <= n1_d;
      s1_q <= s1_d;
      s5_q <= s5_d;
      gnt_a_q <= state_q == IDLE && state_d == CHECK && !owner_d;
      gnt_b_q <= state_q == IDLE && state_d == CHECK && owner_d;
      done_a_q <= state_d == FIN && !fail_d && !owner_d;
      done_b_q <= state_d == FIN && !fail_d && owner_d;
      fail_a_q <= state_d == FIN && fail_d && !owner_d;
      fail_b_q <= state_d == FIN && fail_d && owner_d;
      disp_r1_q <= state_d == PAY1;
      disp_r5_q <= state_d == PAY5;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.fail_a = fail_a_q;
  assign bus.fail_b = fail_b_q;
  assign bus.disp_r1 = disp_r1_q;
  assign bus.disp_r5 = disp_r5_q;
  assign bus.busy = busy_q;
  assign bus.stock_r1 = s1_q;
  assign bus.stock_r5 = s5_q;
endmodule

// File: tb/tb_tonomat_change_arbiter.sv
// tb_tonomat_change_arbiter: directed checks of payout, arbitration, stock limits, refill and reset.
module tb_tonomat_change_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  int n_gnt_a, n_gnt_b, n_done_a, n_done_b, n_fail_a, n_fail_b, n_r1, n_r5, n_ovl;
  int gq[$];
  logic prev_disp = 1'b0, r1_d = 1'b0, r5_d = 1'b0;
  int lat;
  tonomat_change_arbiter_if #(.STOCK_W(6)) bus();
  tonomat_change_arbiter #(.STOCK_W(6), .INIT_R1(20), .INIT_R5(10)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Dispenser: ACK follows DISP delayed by one cycle, rising and falling.
  initial begin
    bus.disp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.disp_ack = prev_disp;
      prev_disp = bus.disp_r1 | bus.disp_r5;
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (bus.gnt_a) begin n_gnt_a++; gq.push_back(0); end
    if (bus.gnt_b) begin n_gnt_b++; gq.push_back(1); end
    if (bus.done_a) n_done_a++;
    if (bus.done_b) n_done_b++;
    if (bus.fail_a) n_fail_a++;
    if (bus.fail_b) n_fail_b++;
    if (bus.disp_r1 && !r1_d) n_r1++;
    if (bus.disp_r5 && !r5_d) n_r5++;
    if (bus.disp_r1 && bus.disp_r5) n_ovl++;
    r1_d = bus.disp_r1;
    r5_d = bus.disp_r5;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {n_gnt_a, n_gnt_b, n_done_a, n_done_b, n_fail_a, n_fail_b, n_r1, n_r5, n_ovl} = '0;
    gq.delete();
  endtask
  task automatic serve(input logic lane, input logic [3:0] amt, output int l);
    if (lane) begin bus.req_b = 1'b1; bus.amt_b = amt; end
    else begin bus.req_a = 1'b1; bus.amt_a = amt; end
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!(lane ? (bus.done_b | bus.fail_b) : (bus.done_a | bus.fail_a)) && l < 300);
    if (lane) bus.req_b = 1'b0;
    else bus.req_a = 1'b0;
    if (l >= 300) chk("serve_timeout", 32'(l), 32'd0);
    @(negedge clk);
  endtask
  task automatic wait_r1();
    int c = 0;
    while (!bus.disp_r1 && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) chk("wait_disp_r1_timeout", 32'(c), 32'd0);
  endtask
  initial begin
    int da, db, cyc, order;
    logic ra, rb;
    {bus.req_a, bus.req_b, bus.refill} = '0;
    {bus.amt_a, bus.amt_b} = '0;
    {bus.refill_r1, bus.refill_r5} = '0;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk("rst_stock_r1", 32'(bus.stock_r1), 32'd20);
    chk("rst_stock_r5", 32'(bus.stock_r5), 32'd10);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_outputs", 32'({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.fail_a, bus.fail_b, bus.disp_r1, bus.disp_r5}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    serve(1'b0, 4'd7, lat);
    chk("a7_latency", 32'(lat), 32'd14);
    chk("a7_gnt_a", 32'(n_gnt_a), 32'd1);
    chk("a7_r5_pulses", 32'(n_r5), 32'd1);
    chk("a7_r1_pulses", 32'(n_r1), 32'd2);
    chk("a7_done_a", 32'(n_done_a), 32'd1);
    chk("a7_fail_a", 32'(n_fail_a), 32'd0);
    chk("a7_overlap", 32'(n_ovl), 32'd0);
    chk("a7_stock_r5", 32'(bus.stock_r5), 32'd9);
    chk("a7_stock_r1", 32'(bus.stock_r1), 32'd18);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    bus.amt_a = 4'd1;
    bus.amt_b = 4'd1;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    da = 0; db = 0; cyc = 0; ra = 1'b0; rb = 1'b0;
    while (da + db < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ra) bus.req_a = 1'b1;
      if (rb) bus.req_b = 1'b1;
      ra = 1'b0;
      rb = 1'b0;
      if (bus.done_a) begin da++; bus.req_a = 1'b0; ra = da < 2; end
      if (bus.done_b) begin db++; bus.req_b = 1'b0; rb = db < 2; end
    end
    if (cyc >= 400) chk("arb_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    order = 0;
    foreach (gq[i]) order = order * 10 + gq[i] + 1;
    chk("arb_order_ABAB", 32'(order), 32'd1212);
    chk("arb_gnt_a", 32'(n_gnt_a), 32'd2);
    chk("arb_gnt_b", 32'(n_gnt_b), 32'd2);
    chk("arb_stock_r1", 32'(bus.stock_r1), 32'd16);
    serve(1'b0, 4'd15, lat);
    chk("a15_latency", 32'(lat), 32'd14);
    serve(1'b0, 4'd15, lat);
    serve(1'b0, 4'd15, lat);
    chk("drain_stock_r5", 32'(bus.stock_r5), 32'd1);
    clr();
    serve(1'b1, 4'd12, lat);
    chk("b12_latency", 32'(lat), 32'd34);
    chk("b12_r5_pulses", 32'(n_r5), 32'd1);
    chk("b12_r1_pulses", 32'(n_r1), 32'd7);
    chk("b12_done_b", 32'(n_done_b), 32'd1);
    chk("b12_overlap", 32'(n_ovl), 32'd0);
    chk("b12_stock_r5", 32'(bus.stock_r5), 32'd0);
    chk("b12_stock_r1", 32'(bus.stock_r1), 32'd9);
    serve(1'b0, 4'd4, lat);
    chk("a4_stock_r1", 32'(bus.stock_r1), 32'd5);
    clr();
    serve(1'b0, 4'd10, lat);
    chk("a10_fail_latency", 32'(lat), 32'd2);
    chk("a10_fail_a", 32'(n_fail_a), 32'd1);
    chk("a10_done_a", 32'(n_done_a), 32'd0);
    chk("a10_no_disp", 32'(n_r1 + n_r5), 32'd0);
    chk("a10_stock", 32'({bus.stock_r5, bus.stock_r1}), 32'd5);
    clr();
    serve(1'b1, 4'd0, lat);
    chk("b0_latency", 32'(lat), 32'd2);
    chk("b0_done_b", 32'(n_done_b), 32'd1);
    chk("b0_no_disp", 32'(n_r1 + n_r5), 32'd0);
    clr();
    bus.refill = 1'b1;
    bus.refill_r1 = 6'd55;
    bus.refill_r5 = 6'd0;
    bus.req_a = 1'b1;
    bus.amt_a = 4'd0;
    @(negedge clk);
    chk("refill_r1_60", 32'(bus.stock_r1), 32'd60);
    chk("refill_no_grant", 32'(n_gnt_a + 32'(bus.busy)), 32'd0);
    bus.refill_r1 = 6'd10;
    bus.refill_r5 = 6'd3;
    @(negedge clk);
    bus.refill = 1'b0;
    bus.req_a = 1'b0;
    chk("refill_r1_sat", 32'(bus.stock_r1), 32'd63);
    chk("refill_r5_add", 32'(bus.stock_r5), 32'd3);
    @(negedge clk);
    clr();
    bus.amt_a = 4'd1;
    bus.req_a = 1'b1;
    wait_r1();
    bus.refill = 1'b1;
    bus.refill_r1 = 6'd5;
    bus.refill_r5 = 6'd5;
    cyc = 0;
    while (!bus.done_a && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) chk("busy_refill_timeout", 32'(cyc), 32'd0);
    bus.refill = 1'b0;
    bus.req_a = 1'b0;
    @(negedge clk);
    chk("busy_refill_r1", 32'(bus.stock_r1), 32'd62);
    chk("busy_refill_r5", 32'(bus.stock_r5), 32'd3);
    chk("busy_refill_done", 32'(n_done_a), 32'd1);
    clr();
    bus.amt_a = 4'd1;
    bus.req_a = 1'b1;
    wait_r1();
    rst_n = 1'b0;
    bus.req_a = 1'b0;
    @(negedge clk);
    chk("midrst_disp_r1", 32'(bus.disp_r1), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_stock", 32'({bus.stock_r5, bus.stock_r1}), 32'd660);
    @(negedge clk);
    chk("midrst_no_pulse", 32'(n_done_a + n_fail_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
